adder_pipe_nbit: RTL and testbench

- Parametrised, pipelined successor to the 16-bit combinational adder.
- Computes a+b+cin or a-b-borrow over WIDTH bits, with the carry chain split across STAGES register stages.
- Carries cout, signed overflow and zero flags alongside the sum.
- Sits between operand producer and result consumer with valid/ready handshakes on both sides; supports back-pressure without data loss.

---
 rtl/adder_pipe_pkg.sv | 43 ++++
 rtl/adder_pipe_stage.sv | 101 ++++++++++
 rtl/adder_pipe_nbit.sv | 102 ++++++++++
 tb/tb_adder_pipe_nbit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// -----------------------------------------------------------------------------
// adder_pipe_pkg
//   Shared types and helpers for the pipelined N-bit adder.
//   - calc_cw          : chunk width carried by each pipeline stage
//   - flags_t          : result flag bundle (cout, overflow, zero)
//   - max_pos/max_neg  : saturation limits for a given width, returned
//                        right-aligned in a MAX_WIDTH vector
// -----------------------------------------------------------------------------
package adder_pipe_pkg;

  localparam int MAX_WIDTH = 64;

  function automatic int calc_cw(input int width, input int stages);
    return width / stages;
  endfunction

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
  } flags_t;

  // 0111..1 over 'width' bits
  function automatic logic [MAX_WIDTH-1:0] max_pos(input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // 1000..0 over 'width' bits
  function automatic logic [MAX_WIDTH-1:0] max_neg(input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i == width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// -----------------------------------------------------------------------------
// adder_pipe_stage
//   One slice of the pipelined adder: adds chunk IDX of a/be plus the carry
//   from the previous slice and registers it together with the forwarded
//   operands, the partial sum and the saturation request. The LAST slice also
//   derives the flags and applies saturation before registering.
//   Ports:
//     clk, rst        clock, synchronous active-low reset
//     up_valid/ready  handshake towards the previous slice (or producer)
//     a_in, be_in     full operand A and effective operand B
//     sum_in          partial sum (chunks below IDX already valid)
//     carry_in        carry into this chunk
//     sat_in          saturation request travelling with the beat
//     down_valid/ready handshake towards the next slice (or consumer)
//     a_out..sat_out  registered copies for the next slice
//     flags_out       registered flags (meaningful in the LAST slice only)
// -----------------------------------------------------------------------------
module adder_pipe_stage
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = 4,
  parameter int IDX   = 0,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] be_in,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  input  logic             sat_in,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] be_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             sat_out,
  output flags_t           flags_out
);

  logic [CW:0]      chunk;
  logic [WIDTH-1:0] sum_next;
  flags_t           flags_next;
  logic             ovf;
  logic             load;

  // Loads when empty or when the current beat leaves this cycle, so bubbles
  // collapse and a full pipe still streams one beat per cycle.
  assign up_ready = !down_valid || down_ready;
  assign load     = up_valid && up_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    chunk      = {1'b0, a_in[IDX*CW +: CW]} + {1'b0, be_in[IDX*CW +: CW]}
               + {{CW{1'b0}}, carry_in};
    sum_next   = sum_in;
    sum_next[IDX*CW +: CW] = chunk[CW-1:0];
    ovf        = 1'b0;
    flags_next = '0;
    if (LAST) begin
      ovf = (a_in[WIDTH-1] == be_in[WIDTH-1]) && (sum_next[WIDTH-1] != a_in[WIDTH-1]);
      // On overflow the true result has the sign of the operands.
      if (sat_in && ovf) begin
        sum_next = a_in[WIDTH-1] ? WIDTH'(max_neg(WIDTH)) : WIDTH'(max_pos(WIDTH));
      end
      flags_next = '{cout: chunk[CW], overflow: ovf, zero: (sum_next == '0)};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every slice
  // samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: datapath registers are reset too, because the last slice drives
      // sum/flags directly and they must read zero after reset.
      down_valid <= 1'b0;
      a_out      <= '0;
      be_out     <= '0;
      sum_out    <= '0;
      carry_out  <= 1'b0;
      sat_out    <= 1'b0;
      flags_out  <= '0;
    end else if (load) begin
      down_valid <= 1'b1;
      a_out      <= a_in;
      be_out     <= be_in;
      sum_out    <= sum_next;
      carry_out  <= chunk[CW];
      sat_out    <= sat_in;
      flags_out  <= flags_next;
    end else if (down_ready) begin
      down_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/adder_pipe_nbit.sv
// -----------------------------------------------------------------------------
// adder_pipe_nbit
//   Pipelined WIDTH-bit adder/subtractor with valid/ready on both sides.
//   The carry chain is split into STAGES chunks of WIDTH/STAGES bits, one per
//   register slice; latency STAGES, throughput one beat per cycle.
//   WIDTH must be a multiple of STAGES.
//   Ports:
//     clk, rst             clock, synchronous active-low reset
//     in_valid/in_ready    operand handshake (in_ready low during reset)
//     a, b, cin, sub       operands; sub=1 computes a-b-cin (cin = borrow)
//     sat                  clamp on signed overflow (ADDER_PIPE_SATURATE_EN)
//     out_valid/out_ready  result handshake
//     sum, cout, overflow, zero  result and flags (cout=1 means no borrow)
//   Optional feature macro: ADDER_PIPE_SATURATE_EN adds the sat input.
// -----------------------------------------------------------------------------
module adder_pipe_nbit
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef ADDER_PIPE_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = calc_cw(WIDTH, STAGES);

  // Index k is the input of slice k; index STAGES is the pipe output.
  logic             v     [STAGES+1];
  logic             r     [STAGES+1];
  logic [WIDTH-1:0] a_p   [STAGES+1];
  logic [WIDTH-1:0] be_p  [STAGES+1];
  logic [WIDTH-1:0] s_p   [STAGES+1];
  logic             c_p   [STAGES+1];
  logic             sat_p [STAGES+1];
  flags_t           f_p   [STAGES+1];

  // Subtraction as a + ~b + ~borrow.
  assign v[0]    = in_valid;
  assign a_p[0]  = a;
  assign be_p[0] = sub ? ~b : b;
  assign s_p[0]  = '0;
  assign c_p[0]  = sub ? ~cin : cin;
  assign f_p[0]  = '0;
`ifdef ADDER_PIPE_SATURATE_EN
  assign sat_p[0] = sat;
`else
  assign sat_p[0] = 1'b0;
`endif

  assign r[STAGES] = out_ready;
  assign in_ready  = rst && r[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_pipe_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .IDX   (k),
      .LAST  (k == STAGES - 1)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (v[k]),
      .up_ready   (r[k]),
      .a_in       (a_p[k]),
      .be_in      (be_p[k]),
      .sum_in     (s_p[k]),
      .carry_in   (c_p[k]),
      .sat_in     (sat_p[k]),
      .down_valid (v[k+1]),
      .down_ready (r[k+1]),
      .a_out      (a_p[k+1]),
      .be_out     (be_p[k+1]),
      .sum_out    (s_p[k+1]),
      .carry_out  (c_p[k+1]),
      .sat_out    (sat_p[k+1]),
      .flags_out  (f_p[k+1])
    );
  end

  assign out_valid = v[STAGES];
  assign sum       = s_p[STAGES];
  assign cout      = f_p[STAGES].cout;
  assign overflow  = f_p[STAGES].overflow;
  assign zero      = f_p[STAGES].zero;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe_nbit
//   Self-checking bench for adder_pipe_nbit (WIDTH=16, STAGES=4). A reference
//   model computes each result from signed/unsigned integer arithmetic; a queue
//   holds expected results in acceptance order.
// -----------------------------------------------------------------------------
module tb_adder_pipe_nbit;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub, sat;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, overflow, zero;

  int errors = 0;
  int checks = 0;

  res_t             exp_q[$];
  logic             got_out, acc, saw_in_stall;
  int               rx;
  logic             held_valid = 1'b0;
  logic [WIDTH-1:0] held_sum;
  logic [2:0]       held_flags;

  always #5 clk = ~clk;

  adder_pipe_nbit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef ADDER_PIPE_SATURATE_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                                 input logic ci, input logic si, input logic sti);
    res_t   r;
    longint sa, sb, tru, u, lim;
    lim = 64'sd1 <<< (WIDTH - 1);
    sa  = longint'($signed(ai));
    sb  = longint'($signed(bi));
    tru = si ? sa - sb - longint'(ci) : sa + sb + longint'(ci);
    u   = si ? longint'(ai) - longint'(bi) - longint'(ci)
             : longint'(ai) + longint'(bi) + longint'(ci);
    r.ovf  = (tru >= lim) || (tru < -lim);
    r.sum  = WIDTH'(u);
    r.cout = si ? (longint'(ai) >= longint'(bi) + longint'(ci)) : (u >= (lim <<< 1));
    if (sti && r.ovf) r.sum = (tru > 0) ? WIDTH'(lim - 1) : WIDTH'(lim);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  // One clock: sample at the falling edge, update model/scoreboard, then step
  // to just after the rising edge where the caller drives new inputs.
  task automatic tick();
    res_t e;
    logic sat_eff;
    @(negedge clk);
    got_out = 1'b0;
    acc     = 1'b0;
`ifdef ADDER_PIPE_SATURATE_EN
    sat_eff = sat;
`else
    sat_eff = 1'b0;
`endif
    if (held_valid) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_sum",   32'(sum), 32'(held_sum));
      check("stall_flags", 32'({cout, overflow, zero}), 32'(held_flags));
    end
    if (in_valid && !in_ready) saw_in_stall = 1'b1;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(a, b, cin, sub, sat_eff));
      acc = 1'b1;
    end
    if (out_valid && out_ready) begin
      got_out = 1'b1;
      rx++;
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sum",      32'(sum),      32'(e.sum));
        check("cout",     32'(cout),     32'(e.cout));
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("zero",     32'(zero),     32'(e.zero));
      end
    end
    held_valid = out_valid && !out_ready;
    held_sum   = sum;
    held_flags = {cout, overflow, zero};
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    a   = WIDTH'($urandom);
    b   = WIDTH'($urandom);
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    sat = 1'($urandom_range(0, 1));
  endtask

  // Single beat into an idle pipe; checks acceptance and exact latency.
  task automatic send_one(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                          input logic ci, input logic si, input logic sti);
    int lat;
    a = ai; b = bi; cin = ci; sub = si; sat = sti;
    in_valid = 1'b1;
    tick();
    check("accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    lat = 0;
    while (!got_out && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(STAGES));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, cyc;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    rx = 0; saw_in_stall = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum), 32'd0);
    check("rst_flags",     32'({cout, overflow, zero}), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Directed arithmetic corners
    send_one(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    send_one(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0);
    send_one(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    send_one(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0);
    send_one(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    send_one(16'h0000, 16'h8000, 1'b1, 1'b1, 1'b0);
`ifdef ADDER_PIPE_SATURATE_EN
    send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    send_one(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    send_one(16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b1);
`endif

    // Back-pressure: 10 back-to-back beats, consumer stalls 6 cycles
    rx = 0; sent = 0; cyc = 0; saw_in_stall = 1'b0;
    rand_beat();
    while (rx < 10 && cyc < 200) begin
      in_valid  = (sent < 10);
      out_ready = !(cyc >= 3 && cyc < 9);
      tick();
      if (acc) begin
        sent++;
        rand_beat();
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_received", 32'(rx), 32'd10);
    check("bp_in_ready_dropped", 32'(saw_in_stall), 32'd1);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random stream with random back-pressure
    rx = 0; sent = 0; cyc = 0;
    rand_beat();
    while (rx < 200 && cyc < 5000) begin
      if (!in_valid || acc) in_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (acc) begin
        sent++;
        rand_beat();
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand_received", 32'(rx), 32'd200);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three beats in flight
    repeat (3) begin
      rand_beat();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    exp_q.delete();
    held_valid = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",       32'(sum), 32'd0);
    check("midrst_flags",     32'({cout, overflow, zero}), 32'd0);
    check("midrst_in_ready",  32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    rx = 0;
    repeat (10) tick();
    check("no_stale_beat", 32'(rx), 32'd0);
    send_one(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
